// File: rtl/sqr_seq_pkg.sv
// Shared constants and types for the SQR job sequencer: register map, FSM states
// and the AXI OKAY response code.
package sqr_seq_pkg;

  localparam logic [31:0] SQR_REG_OPERAND = 32'h0000_0000;
  localparam logic [31:0] SQR_REG_CTRL    = 32'h0000_0004;
  localparam logic [31:0] SQR_REG_STATUS  = 32'h0000_0008;
  localparam logic [31:0] SQR_REG_RESULT  = 32'h0000_000C;

  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic [3:0] {
    IDLE,
    WR_OP,
    WR_OP_B,
    WR_GO,
    WR_GO_B,
    POLL_WAIT,
    RD_STAT,
    RD_STAT_R,
    RD_RES,
    RD_RES_R,
    OUT
  } sqr_state_t;

  function automatic logic is_bus_req(input sqr_state_t s);
    return (s == WR_OP) || (s == WR_GO) || (s == RD_STAT) || (s == RD_RES);
  endfunction

endpackage

// File: rtl/sqr_axil_single_xfer.sv
// Issues one AXI4-Lite read or write per start pulse. AW and W drop independently
// on their own ready; the response phase opens once the address phase completes.
module sqr_axil_single_xfer
  import sqr_seq_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_done,
  output logic        resp_done,
  output logic [1:0]  resp,
  output logic [31:0] rdata,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  logic aw_ok;
  logic w_ok;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

  // A write address phase is finished when each channel is either already gone or leaving now.
  always_comb begin
    aw_ok     = !m_axi_awvalid || m_axi_awready;
    w_ok      = !m_axi_wvalid || m_axi_wready;
    addr_done = ((m_axi_awvalid || m_axi_wvalid) && aw_ok && w_ok) ||
                (m_axi_arvalid && m_axi_arready);
    resp_done = (m_axi_bready && m_axi_bvalid) || (m_axi_rready && m_axi_rvalid);
    resp      = m_axi_rready ? m_axi_rresp : m_axi_bresp;
    rdata     = m_axi_rdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_axi_awaddr  <= 32'h0000_0000;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= 32'h0000_0000;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= 32'h0000_0000;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else if (start) begin
      if (wr) begin
        m_axi_awaddr  <= addr;
        m_axi_wdata   <= wdata;
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
      end else begin
        m_axi_araddr  <= addr;
        m_axi_arvalid <= 1'b1;
      end
    end else begin
      if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
      if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
      if (addr_done) begin
        if (m_axi_awvalid || m_axi_wvalid) m_axi_bready <= 1'b1;
        else                               m_axi_rready <= 1'b1;
      end
      if (m_axi_bready && m_axi_bvalid) m_axi_bready <= 1'b0;
      if (m_axi_rready && m_axi_rvalid) m_axi_rready <= 1'b0;
    end
  end

endmodule

// File: rtl/sqr_job_sequencer.sv
// AXI4-Lite master running one squaring job at a time on the SQR register bank.
// Optional poll limit: define SQR_SEQ_TIMEOUT_EN to bound status reads at C_TIMEOUT.
module sqr_job_sequencer
  import sqr_seq_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
  parameter int unsigned C_POLL_GAP  = 4,
  parameter int unsigned C_TIMEOUT   = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic GAP_ZERO = (C_POLL_GAP == 32'd0);

  sqr_state_t  state;
  sqr_state_t  state_next;
  logic [15:0] poll_cnt;
  logic        xfer_start;
  logic        xfer_wr;
  logic [31:0] xfer_addr;
  logic [31:0] xfer_wdata;
  logic        addr_done;
  logic        resp_done;
  logic [1:0]  resp;
  logic [31:0] rdata;
  logic        bus_err;
  logic        stat_done;
  logic        poll_limit;
  logic        timeout_hit;
  logic        op_ready_next;
  logic        res_valid_next;

  assign bus_err     = resp_done && (resp != OKAY);
  assign stat_done   = rdata[0];
  assign timeout_hit = (state == RD_STAT_R) && resp_done && !bus_err && !stat_done && poll_limit;

`ifdef SQR_SEQ_TIMEOUT_EN
  logic [31:0] stat_cnt;

  assign poll_limit = (stat_cnt == (C_TIMEOUT - 32'd1));

  // Counts status reads that came back not-done within the current job.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      stat_cnt <= 32'd0;
    end else if (state == IDLE) begin
      stat_cnt <= 32'd0;
    end else if ((state == RD_STAT_R) && resp_done && !bus_err && !stat_done) begin
      stat_cnt <= stat_cnt + 32'd1;
    end
  end
`else
  assign poll_limit = 1'b0;
`endif

  sqr_axil_single_xfer u_xfer (
    .clk           (ACLK),
    .resetn        (ARESETN),
    .start         (xfer_start),
    .wr            (xfer_wr),
    .addr          (xfer_addr),
    .wdata         (xfer_wdata),
    .addr_done     (addr_done),
    .resp_done     (resp_done),
    .resp          (resp),
    .rdata         (rdata),
    .m_axi_awaddr  (M_AXI_AWADDR),
    .m_axi_awprot  (M_AXI_AWPROT),
    .m_axi_awvalid (M_AXI_AWVALID),
    .m_axi_awready (M_AXI_AWREADY),
    .m_axi_wdata   (M_AXI_WDATA),
    .m_axi_wstrb   (M_AXI_WSTRB),
    .m_axi_wvalid  (M_AXI_WVALID),
    .m_axi_wready  (M_AXI_WREADY),
    .m_axi_bresp   (M_AXI_BRESP),
    .m_axi_bvalid  (M_AXI_BVALID),
    .m_axi_bready  (M_AXI_BREADY),
    .m_axi_araddr  (M_AXI_ARADDR),
    .m_axi_arprot  (M_AXI_ARPROT),
    .m_axi_arvalid (M_AXI_ARVALID),
    .m_axi_arready (M_AXI_ARREADY),
    .m_axi_rdata   (M_AXI_RDATA),
    .m_axi_rresp   (M_AXI_RRESP),
    .m_axi_rvalid  (M_AXI_RVALID),
    .m_axi_rready  (M_AXI_RREADY)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state     <= IDLE;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_next;
      op_ready  <= op_ready_next;
      res_valid <= res_valid_next;
    end
  end

  // With no poll gap the wait state is skipped entirely rather than visited for one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (op_valid && op_ready) state_next = WR_OP;
      WR_OP:     if (addr_done) state_next = WR_OP_B;
      WR_OP_B:   if (resp_done) state_next = bus_err ? OUT : WR_GO;
      WR_GO:     if (addr_done) state_next = WR_GO_B;
      WR_GO_B: begin
        if (resp_done) begin
          if (bus_err)       state_next = OUT;
          else if (GAP_ZERO) state_next = RD_STAT;
          else               state_next = POLL_WAIT;
        end
      end
      POLL_WAIT: if (poll_cnt == 16'(C_POLL_GAP - 32'd1)) state_next = RD_STAT;
      RD_STAT:   if (addr_done) state_next = RD_STAT_R;
      RD_STAT_R: begin
        if (resp_done) begin
          if (bus_err)         state_next = OUT;
          else if (stat_done)  state_next = RD_RES;
          else if (poll_limit) state_next = OUT;
          else if (GAP_ZERO)   state_next = RD_STAT;
          else                 state_next = POLL_WAIT;
        end
      end
      RD_RES:    if (addr_done) state_next = RD_RES_R;
      RD_RES_R:  if (resp_done) state_next = OUT;
      OUT:       if (res_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    op_ready_next  = (state_next == IDLE);
    res_valid_next = (state_next == OUT);
    xfer_start     = (state_next != state) && is_bus_req(state_next);
    xfer_wr        = (state_next == WR_OP) || (state_next == WR_GO);
    case (state_next)
      WR_OP: begin
        xfer_addr  = C_BASE_ADDR + SQR_REG_OPERAND;
        xfer_wdata = op_data;
      end
      WR_GO: begin
        xfer_addr  = C_BASE_ADDR + SQR_REG_CTRL;
        xfer_wdata = 32'h0000_0001;
      end
      RD_STAT: begin
        xfer_addr  = C_BASE_ADDR + SQR_REG_STATUS;
        xfer_wdata = 32'h0000_0000;
      end
      RD_RES: begin
        xfer_addr  = C_BASE_ADDR + SQR_REG_RESULT;
        xfer_wdata = 32'h0000_0000;
      end
      default: begin
        xfer_addr  = C_BASE_ADDR;
        xfer_wdata = 32'h0000_0000;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      poll_cnt <= 16'd0;
      res_data <= 32'h0000_0000;
      res_err  <= 1'b0;
    end else begin
      if ((state == POLL_WAIT) && (state_next == POLL_WAIT)) poll_cnt <= poll_cnt + 16'd1;
      else                                                  poll_cnt <= 16'd0;
      if ((state == OUT) && res_ready) begin
        res_err <= 1'b0;
      end else if (bus_err || timeout_hit) begin
        res_err  <= 1'b1;
        res_data <= 32'h0000_0000;
      end else if ((state == RD_RES_R) && resp_done) begin
        res_data <= rdata;
      end
    end
  end

endmodule

// File: doc/sqr_job_sequencer.md
# sqr_job_sequencer

AXI4-Lite master that runs one squaring job at a time on the SQR register-bank peripheral. It accepts an operand on a valid/ready stream and writes it to the operand register. It then writes the start bit, polls the status register until done, reads the result and presents it on an output valid/ready stream. It sits between the processing pipeline and the SQR slave's S00_AXI port, replacing software-driven register access.

## Interface
- C_BASE_ADDR, 32'h0000_0000: byte base address of the SQR register bank.
- C_POLL_GAP, 4: idle cycles between consecutive status reads (0 allowed).
- C_TIMEOUT, 1024: maximum status reads per job (used only with SQR_SEQ_TIMEOUT_EN).
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  synchronous, active-low reset.
- op_valid / op_ready  in/out  1  operand handshake.
- op_data  in  32  operand.
- res_valid / res_ready  out/in  1  result handshake.
- res_data  out  32  result word.
- res_err  out  1  job failed (bus error or timeout); qualified by res_valid.
- M_AXI_AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY: standard AXI4-Lite master channels; 32-bit address and data, 3-bit PROT (driven 3'b000), 4-bit WSTRB (driven 4'hF).

## Operation
- Register map (byte offsets from C_BASE_ADDR): 0x0 operand, 0x4 control (bit0 = start), 0x8 status (bit0 = done), 0xC result.
- States: IDLE, WR_OP, WR_OP_B, WR_GO, WR_GO_B, POLL_WAIT, RD_STAT, RD_STAT_R, RD_RES, RD_RES_R, OUT.
- IDLE: op_ready=1. op_valid&op_ready captures op_data and moves to WR_OP.
- WR_OP / WR_GO: AWVALID and WVALID rise together. Each drops independently on its own ready. The state advances when both have been accepted.
  - WR_OP data = operand, address base+0x0.
  - WR_GO data = 32'h1, address base+0x4.
- WR_*_B: BREADY=1. On BVALID, BRESP!=OKAY sets err and goes to OUT; otherwise WR_OP_B goes to WR_GO and WR_GO_B goes to POLL_WAIT.
- POLL_WAIT: count C_POLL_GAP cycles, then go to RD_STAT.
- RD_STAT / RD_RES: ARVALID=1 until ARREADY. Address is base+0x8 or base+0xC.
- RD_*_R: RREADY=1. On RVALID, RRESP!=OKAY sets err and goes to OUT.
  - RD_STAT_R with RDATA[0]=1 goes to RD_RES; with RDATA[0]=0 goes to POLL_WAIT.
  - RD_RES_R latches RDATA into res_data and goes to OUT.
- OUT: res_valid=1. res_data and res_err are held stable until res_ready, then the block returns to IDLE and clears err.
- On error, res_data = 0.
- Only one AXI transaction is outstanding at any time. AW/W and AR are never issued concurrently.

## Timing
- Reset: all outputs 0 (op_ready, res_valid, res_data, res_err, every *VALID, BREADY, RREADY). State = IDLE, poll counter = 0.
- ARESETN low mid-job aborts immediately to IDLE. No B/R response is awaited.
- VALID signals are registered and never depend combinationally on READY.
- Reference latency: slave asserts ready in the same cycle as valid and responds the next cycle, C_POLL_GAP=0, done on the first poll. Under these conditions, op accept at cycle 0 gives res_valid at cycle 9.
- Back-to-back jobs: op_ready returns 1 in the cycle after the res handshake.
- BVALID/RVALID arriving before the *_B/*_R state is impossible in a protocol-correct system and needs no handling.

## Configuration
- SQR_SEQ_TIMEOUT_EN defined: a counter counts status reads per job. When C_TIMEOUT reads have returned done=0, the next state is OUT with res_err=1 and res_data=0. No further read is issued.
- SQR_SEQ_TIMEOUT_EN undefined: polling is unbounded, C_TIMEOUT is ignored, and the counter logic is absent.

## Structure
- Package sqr_seq_pkg holds:
  - the register offset constants (SQR_REG_OPERAND, SQR_REG_CTRL, SQR_REG_STATUS, SQR_REG_RESULT);
  - the state enum typedef;
  - the AXI response constant OKAY=2'b00.
- One sub-module, sqr_axil_single_xfer: issues one AXI4-Lite read or write, returns data and resp, and includes the AW/W independent-drop logic. The top FSM sequences its calls.

## Test plan
- Zero-wait slave model, op 0x0000_0007, done on first poll -> writes 0x7@0x0 then 0x1@0x4, reads 0x8 then 0xC. res_data=0x0000_0031, res_err=0, res_valid at cycle 9.
- Slave returns done=0 three times, C_POLL_GAP=4 -> exactly 4 status reads, with ≥4 idle cycles between ARVALIDs. Result is correct.
- AWREADY delayed 3 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID is held 4 cycles, one B is consumed.
- BRESP=SLVERR on the operand write -> no start write is issued; res_valid with res_err=1 and res_data=0.
- With SQR_SEQ_TIMEOUT_EN, C_TIMEOUT=8, done never set -> 8 status reads, then res_err=1. Without the macro, reads continue past 100.
- ARESETN pulsed low during RD_STAT_R, then op_valid with 0x0000_0003 -> all outputs 0 during reset; the next job completes with res_data=0x9.
